// File: rtl/riscv_pkg.sv
// riscv_pkg: MMIO addresses, STATUS register bit layout and the serial TX state type
// shared by the data-memory responder and its UART serializer.
// Optional feature macro: DMEM_TX_PARITY_EN (adds an even-parity bit to every frame).
package riscv_pkg;

    localparam logic [31:0] MMIO_TX_DATA   = 32'h1000_0000;
    localparam logic [31:0] MMIO_TX_STATUS = 32'h1000_0004;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef DMEM_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer (8E1 when DMEM_TX_PARITY_EN is defined). Accepts a byte
// while idle and shifts it out LSB first, each bit held for CLKS_PER_BIT cycles.
module uart_tx
    import riscv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_nxt;
    logic [CW-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    frame_q;
    logic          bit_done;

    assign ready = (state == TX_IDLE);
    assign busy  = !ready;

    // Byte being transmitted; captured on the handshake and held for the whole frame
    always_ff @(posedge clk) begin
        if (valid && ready) frame_q <= data;
    end

    // State, bit-period counter and data-bit index
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= TX_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // Next-state and line level; the line is decoded from state so reset idles it at once
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        tx          = 1'b1;
        bit_done    = (clk_cnt == LAST_CLK);
        if (state != TX_IDLE) clk_cnt_nxt = bit_done ? '0 : clk_cnt + 1'b1;
        case (state)
            TX_IDLE: begin
                if (valid) state_nxt = TX_START;
            end
            TX_START: begin
                tx = 1'b0;
                if (bit_done) state_nxt = TX_DATA;
            end
            TX_DATA: begin
                tx = frame_q[bit_cnt];
                if (bit_done) begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef DMEM_TX_PARITY_EN
                        state_nxt = TX_PARITY;
`else
                        state_nxt = TX_STOP;
`endif
                    end
                end
            end
`ifdef DMEM_TX_PARITY_EN
            TX_PARITY: begin
                tx = ^frame_q;
                if (bit_done) state_nxt = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (bit_done) state_nxt = TX_IDLE;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: core data-memory slave. Word RAM at address 0, plus a memory-mapped
// UART transmitter (TXDATA / STATUS) fed through a small TX FIFO.
// Optional feature macro: DMEM_TX_PARITY_EN (even parity bit in each serial frame).
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RAM_WORDS    = 1024,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            memory_write_enable,
    input  logic [XLEN-1:0] memory_address,
    input  logic [XLEN-1:0] memory_write_data,
    output logic [XLEN-1:0] memory_read_data,
    output logic            uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     DEPTH_CNT = FIFO_DEPTH[PW:0];
    localparam logic [XLEN-1:0] TXD_ADDR  = XLEN'(MMIO_TX_DATA);
    localparam logic [XLEN-1:0] STS_ADDR  = XLEN'(MMIO_TX_STATUS);

    logic [XLEN-1:0] ram [RAM_WORDS];
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     fifo_cnt;
    logic            overflow;
    logic            ram_sel, txd_sel, sts_sel;
    logic            fifo_full, fifo_empty;
    logic            push_req, push_ok, pop, ovf_clr;
    logic            tx_ready, tx_busy;
    logic [XLEN-1:0] status_word;
    logic            unused_addr_lsbs;

    // Byte offset within a word has no meaning here; all accesses are whole words
    assign unused_addr_lsbs = ^memory_address[1:0];

    assign ram_sel = (memory_address[XLEN-1:AW+2] == '0);
    assign txd_sel = (memory_address[XLEN-1:2] == TXD_ADDR[XLEN-1:2]);
    assign sts_sel = (memory_address[XLEN-1:2] == STS_ADDR[XLEN-1:2]);

    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = tx_ready && !fifo_empty;
    assign push_req   = memory_write_enable && txd_sel;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_clr    = memory_write_enable && sts_sel && memory_write_data[STATUS_OVF_BIT];

    // RAM: synchronous write, combinational read; contents are never reset
    always_ff @(posedge clk) begin
        if (memory_write_enable && ram_sel) ram[memory_address[2 +: AW]] <= memory_write_data;
    end

    // FIFO storage: written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= memory_write_data[7:0];
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    // STATUS register image
    always_comb begin
        status_word                   = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_BUSY_BIT]  = tx_busy;
        status_word[STATUS_OVF_BIT]   = overflow;
    end

    // Load data mux; TXDATA and unmapped space read as zero
    always_comb begin
        memory_read_data = '0;
        if (ram_sel)      memory_read_data = ram[memory_address[2 +: AW]];
        else if (sts_sel) memory_read_data = status_word;
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .n_rst(n_rst),
        .valid(!fifo_empty),
        .data (fifo_mem[rd_ptr]),
        .ready(tx_ready),
        .busy (tx_busy),
        .tx   (uart_tx)
    );

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter XLEN, 32, data/address width.
REQ-002 Parameter RAM_WORDS, 1024, RAM depth in XLEN-bit words (power of two).
REQ-003 Parameter FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).
REQ-004 Parameter CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 n_rst  input  1  reset, asynchronous assert, active-low.
REQ-007 memory_write_enable  input  1  store strobe from core, one store per cycle when high.
REQ-008 memory_address  input  XLEN  byte address; bits [1:0] ignored.
REQ-009 memory_write_data  input  XLEN  store data.
REQ-010 memory_read_data  output  XLEN  load data, combinational from memory_address.
REQ-011 uart_tx  output  1  serial line, idle high.

Function
REQ-012 Map: RAM at 0x0000_0000..RAM_WORDS*4-1; TXDATA at MMIO_TX_DATA (0x1000_0000); STATUS at MMIO_TX_STATUS (0x1000_0004); all else unmapped.
REQ-013 RAM read: memory_read_data = word[memory_address[2 +: log2(RAM_WORDS)]], zero cycles latency.
REQ-014 RAM write: word updated on the rising edge with write_enable high; same-cycle read returns the old value.
REQ-015 TXDATA write pushes memory_write_data[7:0] into the FIFO; TXDATA read returns 0.
REQ-016 STATUS read: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy (FSM not IDLE), bit3 overflow (sticky), others 0.
REQ-017 STATUS write with data bit3=1 clears overflow; other bits are ignored.
REQ-018 Push accepted iff FIFO not full or a pop occurs in the same cycle; a rejected push sets overflow and leaves the FIFO unchanged.
REQ-019 Unmapped: writes dropped without side effect, reads return 0.
REQ-020 TX FSM states IDLE, START, DATA, PARITY (macro only), STOP; each non-IDLE state lasts exactly CLKS_PER_BIT cycles.
REQ-021 IDLE: uart_tx=1; if the FIFO is non-empty, pop the head into the shift register and enter START on the same edge.
REQ-022 START drives 0; DATA drives bits 0..7 LSB first, with a 3-bit counter wrapping after bit 7; STOP drives 1 and then returns to IDLE.
REQ-023 Back-to-back frames: IDLE lasts exactly one cycle between STOP and the next START when the FIFO is non-empty.
REQ-024 FIFO read/write pointers wrap modulo FIFO_DEPTH; an extra occupancy count bit distinguishes full from empty.

Reset
REQ-025 On n_rst low, asynchronously: FSM=IDLE, uart_tx=1, FIFO empty, pointers=0, overflow=0, bit and cycle counters=0.
REQ-026 RAM contents are not reset; they are undefined until written.
REQ-027 Reset mid-frame aborts the frame immediately (uart_tx=1) and discards the FIFO contents.

Configuration
REQ-028 Macro DMEM_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, driving even parity (XOR of the 8 data bits); frame = 11 bits.
REQ-029 Macro DMEM_TX_PARITY_EN undefined: no PARITY state or logic; DATA goes directly to STOP; frame = 10 bits.

Structure
REQ-030 riscv_pkg holds MMIO_TX_DATA, MMIO_TX_STATUS, the STATUS bit-index constants, and the tx_state_t enum.
REQ-031 The serializer FSM is sub-module uart_tx (ports clk, n_rst, valid, data[7:0], ready, busy, tx); FIFO, RAM and address decode live in dmem_responder.

Verification
REQ-032 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0013 -> 0xDEADBEEF; a same-cycle read during the write -> previous value.
REQ-033 Write 0x155 to TXDATA with CLKS_PER_BIT=4 -> uart_tx 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0, then stop 1 (parity bit 0 when the macro is defined).
REQ-034 Write FIFO_DEPTH+2 bytes on consecutive cycles while idle -> first byte pops immediately, FIFO_DEPTH bytes accepted, last write rejected, STATUS=0x0D (full, busy, overflow); write STATUS=0x8 -> bit3 cleared.
REQ-035 Push while full in the exact cycle the FSM pops -> push accepted, overflow stays 0, all bytes are transmitted in order.
REQ-036 Assert n_rst during a DATA bit -> uart_tx=1 with no clock edge, STATUS=0x02 after release, no further frame output.
REQ-037 Write to 0x2000_0000, then read it -> 0; RAM and FIFO unchanged.
